// File: rtl/mac_tx_arbiter_if.sv
// Header + payload channel bundle used on both sides of the MAC TX arbiter.
// master drives valids/fields/payload, slave drives the two readys.
interface mac_tx_arbiter_if #(
    parameter int DATA_WIDTH = 128
);
    logic                      wHdr_valid;
    logic                      wHdr_ready;
    logic [47:0]               bHdr_DstMacAddr;
    logic [47:0]               bHdr_SrcMacAddr;
    logic [15:0]               bHdr_FrameType;
    logic                      wData_valid;
    logic                      wData_ready;
    logic [DATA_WIDTH-1:0]     bData_data;
    logic [DATA_WIDTH/8-1:0]   bData_keep;
    logic                      wData_last;

    modport master (
        output wHdr_valid, bHdr_DstMacAddr, bHdr_SrcMacAddr, bHdr_FrameType,
        input  wHdr_ready,
        output wData_valid, bData_data, bData_keep, wData_last,
        input  wData_ready
    );

    modport slave (
        input  wHdr_valid, bHdr_DstMacAddr, bHdr_SrcMacAddr, bHdr_FrameType,
        output wHdr_ready,
        input  wData_valid, bData_data, bData_keep, wData_last,
        output wData_ready
    );
endinterface

// File: rtl/mac_tx_arbiter.sv
// Frame-granular 2:1 arbiter in front of the MAC TX framer.
// Port 0 = ARP source, port 1 = IP source. A grant is held from header
// acceptance until the payload last handshake. ARB_MODE 0 = round-robin,
// 1 = fixed priority (port 0 wins).
// Optional: define MAC_TX_ARB_STATS_EN to add per-port frame counters and a
// saturating contention counter.
module mac_tx_arbiter #(
    parameter int ARB_MODE   = 0,
    parameter int DATA_WIDTH = 128
) (
    input  logic                    wClk,
    input  logic                    wRst,
    mac_tx_arbiter_if.slave         in0_i,
    mac_tx_arbiter_if.slave         in1_i,
    mac_tx_arbiter_if.master        out_o,
    output logic                    bGrant
`ifdef MAC_TX_ARB_STATS_EN
    ,
    output logic [31:0]             bStat_frames0,
    output logic [31:0]             bStat_frames1,
    output logic [15:0]             bStat_conflicts
`endif
);
    localparam int KW = DATA_WIDTH / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        grant_q, grant_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic        hdr_vld_q, hdr_vld_d;
    logic [47:0] dst_q, dst_d;
    logic [47:0] src_q, src_d;
    logic [15:0] type_q, type_d;

    logic        sel_s;
    logic        hdr_hs_s;
    logic        last_hs_s;

    // Arbitration: pick a port among the current header requests
    always_comb begin
        if (ARB_MODE == 32'sd1) begin
            sel_s = in0_i.wHdr_valid ? 1'b0 : 1'b1;
        end else if (in0_i.wHdr_valid && in1_i.wHdr_valid) begin
            sel_s = ~rr_ptr_q;
        end else if (in0_i.wHdr_valid) begin
            sel_s = 1'b0;
        end else begin
            sel_s = 1'b1;
        end
    end

    // Header accept: only in IDLE, only the selected port, only while it requests
    always_comb begin
        in0_i.wHdr_ready = (state_q == ST_IDLE) && !sel_s && in0_i.wHdr_valid;
        in1_i.wHdr_ready = (state_q == ST_IDLE) &&  sel_s && in1_i.wHdr_valid;
        hdr_hs_s = (in0_i.wHdr_valid && in0_i.wHdr_ready) ||
                   (in1_i.wHdr_valid && in1_i.wHdr_ready);
    end

    // Payload pass-through of the granted port during DATA, quiet otherwise
    always_comb begin
        out_o.wData_valid = 1'b0;
        out_o.bData_data  = {DATA_WIDTH{1'b0}};
        out_o.bData_keep  = {KW{1'b0}};
        out_o.wData_last  = 1'b0;
        in0_i.wData_ready = 1'b0;
        in1_i.wData_ready = 1'b0;
        if (state_q == ST_DATA) begin
            if (grant_q == 1'b0) begin
                out_o.wData_valid = in0_i.wData_valid;
                out_o.bData_data  = in0_i.bData_data;
                out_o.bData_keep  = in0_i.bData_keep;
                out_o.wData_last  = in0_i.wData_last;
                in0_i.wData_ready = out_o.wData_ready;
            end else begin
                out_o.wData_valid = in1_i.wData_valid;
                out_o.bData_data  = in1_i.bData_data;
                out_o.bData_keep  = in1_i.bData_keep;
                out_o.wData_last  = in1_i.wData_last;
                in1_i.wData_ready = out_o.wData_ready;
            end
        end else begin
            out_o.wData_valid = 1'b0;
        end
    end

    // End-of-frame detection on the merged payload stream
    always_comb begin
        last_hs_s = (state_q == ST_DATA) && out_o.wData_valid &&
                    out_o.wData_ready && out_o.wData_last;
    end

    // Next-state logic for the IDLE -> HDR -> DATA frame cycle
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        hdr_vld_d = hdr_vld_q;
        dst_d     = dst_q;
        src_d     = src_q;
        type_d    = type_q;
        case (state_q)
            ST_IDLE: begin
                if (hdr_hs_s) begin
                    state_d   = ST_HDR;
                    grant_d   = sel_s;
                    hdr_vld_d = 1'b1;
                    dst_d     = sel_s ? in1_i.bHdr_DstMacAddr : in0_i.bHdr_DstMacAddr;
                    src_d     = sel_s ? in1_i.bHdr_SrcMacAddr : in0_i.bHdr_SrcMacAddr;
                    type_d    = sel_s ? in1_i.bHdr_FrameType  : in0_i.bHdr_FrameType;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (out_o.wHdr_ready) begin
                    hdr_vld_d = 1'b0;
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_DATA: begin
                if (last_hs_s) begin
                    rr_ptr_d = grant_q;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                hdr_vld_d = 1'b0;
            end
        endcase
    end

    // State and latched-header registers with synchronous reset
    always_ff @(posedge wClk) begin
        if (wRst) begin
            state_q   <= ST_IDLE;
            grant_q   <= 1'b1;
            rr_ptr_q  <= 1'b1;
            hdr_vld_q <= 1'b0;
            dst_q     <= 48'd0;
            src_q     <= 48'd0;
            type_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            hdr_vld_q <= hdr_vld_d;
            dst_q     <= dst_d;
            src_q     <= src_d;
            type_q    <= type_d;
        end
    end

    assign out_o.wHdr_valid      = hdr_vld_q;
    assign out_o.bHdr_DstMacAddr = dst_q;
    assign out_o.bHdr_SrcMacAddr = src_q;
    assign out_o.bHdr_FrameType  = type_q;
    assign bGrant                = grant_q;

`ifdef MAC_TX_ARB_STATS_EN
    logic [31:0] frames0_q;
    logic [31:0] frames1_q;
    logic [15:0] conflicts_q;

    // Frame counters (wrapping) and contention counter (saturating)
    always_ff @(posedge wClk) begin
        if (wRst) begin
            frames0_q   <= 32'd0;
            frames1_q   <= 32'd0;
            conflicts_q <= 16'd0;
        end else begin
            if (last_hs_s && !grant_q) begin
                frames0_q <= frames0_q + 32'd1;
            end
            if (last_hs_s && grant_q) begin
                frames1_q <= frames1_q + 32'd1;
            end
            if ((state_q == ST_IDLE) && in0_i.wHdr_valid && in1_i.wHdr_valid &&
                (conflicts_q != 16'hFFFF)) begin
                conflicts_q <= conflicts_q + 16'd1;
            end
        end
    end

    assign bStat_frames0   = frames0_q;
    assign bStat_frames1   = frames1_q;
    assign bStat_conflicts = conflicts_q;
`endif
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Scoreboard bench for mac_tx_arbiter: two DUTs (round-robin and fixed
// priority), per-port frame drivers fed from queues, and a monitor per DUT
// popping expected headers/beats on every output handshake.
`timescale 1ns/1ps
module tb_mac_tx_arbiter;
    localparam int DW = 128;
    localparam int KW = DW / 8;

    typedef struct {
        logic [47:0]   dst;
        logic [47:0]   src;
        logic [15:0]   ftype;
        int            nbeats;
        logic [7:0]    id;
        logic [KW-1:0] last_keep;
    } frame_t;

    typedef struct {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] ftype;
        logic        grant;
    } hdr_exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_exp_t;

    logic wClk = 1'b0;
    always #5 wClk = ~wClk;

    logic rst_v [2];
    logic hdr_rdy_v [2];
    logic dat_rdy_v [2];

    frame_t    src_q  [4][$];
    hdr_exp_t  hexp_q [2][$];
    beat_exp_t bexp_q [2][$];
    int beats_seen [2];

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [DW-1:0] beat_data(input logic [7:0] id, input int b);
        logic [7:0] bb;
        bb = b[7:0];
        return {id, bb, 112'h0123_4567_89AB_CDEF_0011_2233_4455};
    endfunction

    function automatic frame_t mk(input logic [7:0] id, input logic [47:0] dst,
                                  input logic [15:0] ft, input int n, input logic [KW-1:0] lk);
        frame_t f;
        f.dst = dst; f.src = {40'h02_0000_0000, id}; f.ftype = ft;
        f.nbeats = n; f.id = id; f.last_keep = lk;
        return f;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_frame(input int d, input int p, input frame_t f, input int n_exp);
        hdr_exp_t  h;
        beat_exp_t e;
        src_q[2*d+p].push_back(f);
        h.dst = f.dst; h.src = f.src; h.ftype = f.ftype; h.grant = (p == 1);
        hexp_q[d].push_back(h);
        for (int b = 0; b < n_exp; b++) begin
            e.data = beat_data(f.id, b);
            e.keep = (b == f.nbeats - 1) ? f.last_keep : {KW{1'b1}};
            e.last = (b == f.nbeats - 1);
            bexp_q[d].push_back(e);
        end
    endtask

    task automatic wait_drain(input int d, input string nm);
        int to;
        to = 0;
        while ((hexp_q[d].size() != 0 || bexp_q[d].size() != 0 ||
                src_q[2*d].size() != 0 || src_q[2*d+1].size() != 0) && to < 500) begin
            @(negedge wClk);
            to++;
        end
        chk(nm, 64'(to < 500), 64'd1);
        repeat (3) @(negedge wClk);
    endtask

    for (genvar d = 0; d < 2; d++) begin : g_dut
        mac_tx_arbiter_if #(.DATA_WIDTH(DW)) in0_if ();
        mac_tx_arbiter_if #(.DATA_WIDTH(DW)) in1_if ();
        mac_tx_arbiter_if #(.DATA_WIDTH(DW)) out_if ();
        logic grant_s;
`ifdef MAC_TX_ARB_STATS_EN
        logic [31:0] frames0_s;
        logic [31:0] frames1_s;
        logic [15:0] conflicts_s;
`endif

        mac_tx_arbiter #(.ARB_MODE(d), .DATA_WIDTH(DW)) u_dut (
            .wClk   (wClk),
            .wRst   (rst_v[d]),
            .in0_i  (in0_if),
            .in1_i  (in1_if),
            .out_o  (out_if),
            .bGrant (grant_s)
`ifdef MAC_TX_ARB_STATS_EN
            ,
            .bStat_frames0   (frames0_s),
            .bStat_frames1   (frames1_s),
            .bStat_conflicts (conflicts_s)
`endif
        );

        assign out_if.wHdr_ready  = hdr_rdy_v[d];
        assign out_if.wData_ready = dat_rdy_v[d];

        for (genvar p = 0; p < 2; p++) begin : g_src
            localparam int S = 2*d + p;
            logic          hv, dv, dl, hr, dr;
            logic [47:0]   hdst, hsrc;
            logic [15:0]   htyp;
            logic [DW-1:0] dd;
            logic [KW-1:0] dk;

            if (p == 0) begin : g_c
                assign in0_if.wHdr_valid      = hv;
                assign in0_if.bHdr_DstMacAddr = hdst;
                assign in0_if.bHdr_SrcMacAddr = hsrc;
                assign in0_if.bHdr_FrameType  = htyp;
                assign in0_if.wData_valid     = dv;
                assign in0_if.bData_data      = dd;
                assign in0_if.bData_keep      = dk;
                assign in0_if.wData_last      = dl;
                assign hr = in0_if.wHdr_ready;
                assign dr = in0_if.wData_ready;
            end else begin : g_c
                assign in1_if.wHdr_valid      = hv;
                assign in1_if.bHdr_DstMacAddr = hdst;
                assign in1_if.bHdr_SrcMacAddr = hsrc;
                assign in1_if.bHdr_FrameType  = htyp;
                assign in1_if.wData_valid     = dv;
                assign in1_if.bData_data      = dd;
                assign in1_if.bData_keep      = dk;
                assign in1_if.wData_last      = dl;
                assign hr = in1_if.wHdr_ready;
                assign dr = in1_if.wData_ready;
            end

            // Source driver: header and first payload beat are offered together
            initial begin : drv
                frame_t f;
                int     b;
                bit     busy, hh, dh;
                busy = 1'b0; b = 0;
                hv = 1'b0; dv = 1'b0; dl = 1'b0;
                hdst = 48'd0; hsrc = 48'd0; htyp = 16'd0;
                dd = {DW{1'b0}}; dk = {KW{1'b0}};
                f = mk(8'd0, 48'd0, 16'd0, 1, {KW{1'b0}});
                forever begin
                    @(negedge wClk);
                    hh = hv & hr;
                    dh = dv & dr;
                    @(posedge wClk);
                    #1;
                    if (rst_v[d]) begin
                        busy = 1'b0; hv = 1'b0; dv = 1'b0; dl = 1'b0;
                    end else begin
                        if (hh) hv = 1'b0;
                        if (dh) begin
                            if (dl) begin
                                busy = 1'b0; dv = 1'b0; dl = 1'b0;
                            end else begin
                                b++;
                                dd = beat_data(f.id, b);
                                dl = (b == f.nbeats - 1);
                                dk = dl ? f.last_keep : {KW{1'b1}};
                            end
                        end
                    end
                    if (!busy && !rst_v[d] && src_q[S].size() > 0) begin
                        f = src_q[S].pop_front();
                        busy = 1'b1; b = 0;
                        hv = 1'b1; hdst = f.dst; hsrc = f.src; htyp = f.ftype;
                        dv = 1'b1; dd = beat_data(f.id, 0);
                        dl = (f.nbeats == 1);
                        dk = dl ? f.last_keep : {KW{1'b1}};
                    end
                end
            end
        end

        // Monitor: compare every output header / payload handshake to the scoreboard
        initial begin : mon
            hdr_exp_t  he;
            beat_exp_t be;
            beats_seen[d] = 0;
            forever begin
                @(negedge wClk);
                if (!rst_v[d]) begin
                    if (out_if.wHdr_valid && out_if.wHdr_ready) begin
                        n_cmp++;
                        if (hexp_q[d].size() == 0) begin
                            n_fail++;
                            $display("FAIL hdr_unexpected dut%0d: got dst %0h type %0h, none expected",
                                     d, out_if.bHdr_DstMacAddr, out_if.bHdr_FrameType);
                        end else begin
                            he = hexp_q[d].pop_front();
                            if (out_if.bHdr_DstMacAddr !== he.dst || out_if.bHdr_SrcMacAddr !== he.src ||
                                out_if.bHdr_FrameType !== he.ftype || grant_s !== he.grant) begin
                                n_fail++;
                                $display("FAIL hdr dut%0d: got %0h/%0h/%0h g%0b expected %0h/%0h/%0h g%0b", d,
                                         out_if.bHdr_DstMacAddr, out_if.bHdr_SrcMacAddr, out_if.bHdr_FrameType,
                                         grant_s, he.dst, he.src, he.ftype, he.grant);
                            end
                        end
                    end
                    if (out_if.wData_valid && out_if.wData_ready) begin
                        n_cmp++;
                        beats_seen[d]++;
                        if (bexp_q[d].size() == 0) begin
                            n_fail++;
                            $display("FAIL beat_unexpected dut%0d: got %0h, none expected", d, out_if.bData_data);
                        end else begin
                            be = bexp_q[d].pop_front();
                            if (out_if.bData_data !== be.data || out_if.bData_keep !== be.keep ||
                                out_if.wData_last !== be.last) begin
                                n_fail++;
                                $display("FAIL beat dut%0d: got %0h k%0h l%0b expected %0h k%0h l%0b", d,
                                         out_if.bData_data, out_if.bData_keep, out_if.wData_last,
                                         be.data, be.keep, be.last);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int to, base;
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b1; hdr_rdy_v[i] = 1'b1; dat_rdy_v[i] = 1'b1;
        end
        repeat (3) @(posedge wClk);
        #1;
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        @(negedge wClk);

        // Reset state
        chk("rst_hdr_valid_d0", 64'(g_dut[0].out_if.wHdr_valid), 64'd0);
        chk("rst_hdr_dst_d0",   64'(g_dut[0].out_if.bHdr_DstMacAddr), 64'd0);
        chk("rst_hdr_type_d0",  64'(g_dut[0].out_if.bHdr_FrameType), 64'd0);
        chk("rst_data_valid_d0", 64'(g_dut[0].out_if.wData_valid), 64'd0);
        chk("rst_grant_d0",     64'(g_dut[0].grant_s), 64'd1);
        chk("rst_grant_d1",     64'(g_dut[1].grant_s), 64'd1);
        chk("rst_hdr_valid_d1", 64'(g_dut[1].out_if.wHdr_valid), 64'd0);

        // Reset mid-frame on beat 2 of a 4-beat port-0 frame
        push_frame(0, 0, mk(8'h06, 48'h0A0B_0C0D_0E0F, 16'h0800, 4, 16'h00FF), 2);
        base = beats_seen[0];
        to = 0;
        while (beats_seen[0] < base + 2 && to < 100) begin
            @(posedge wClk);
            #1;
            to++;
        end
        chk("rstmid_reach_beat2", 64'(to < 100), 64'd1);
        rst_v[0] = 1'b1;
        @(posedge wClk);
        #2;
        chk("rstmid_grant",     64'(g_dut[0].grant_s), 64'd1);
        chk("rstmid_hdr_valid", 64'(g_dut[0].out_if.wHdr_valid), 64'd0);
        chk("rstmid_data_valid", 64'(g_dut[0].out_if.wData_valid), 64'd0);
        chk("rstmid_in0_dready", 64'(g_dut[0].in0_if.wData_ready), 64'd0);
        chk("rstmid_hdr_dst",   64'(g_dut[0].out_if.bHdr_DstMacAddr), 64'd0);
        @(posedge wClk);
        #3;
        rst_v[0] = 1'b0;
        push_frame(0, 1, mk(8'h07, 48'h1111_2222_3333, 16'h86DD, 2, 16'h0003), 2);
        wait_drain(0, "rstmid_after_frame_drain");

        // Round-robin contention: expected order 0,1,0,1
        push_frame(0, 0, mk(8'h10, 48'hFFFF_FFFF_FFFF, 16'h0806, 2, 16'h0FFF), 2);
        push_frame(0, 1, mk(8'h11, 48'h00AA_BBCC_DDEE, 16'h0800, 3, 16'h7FFF), 3);
        push_frame(0, 0, mk(8'h12, 48'hFFFF_FFFF_FFFF, 16'h0806, 1, 16'h0001), 1);
        push_frame(0, 1, mk(8'h13, 48'h00AA_BBCC_DDEF, 16'h0800, 2, 16'hFFFF), 2);
        @(negedge wClk);
        to = 0;
        while (!(g_dut[0].in0_if.wHdr_valid && g_dut[0].in0_if.wHdr_ready) && to < 50) begin
            @(negedge wClk);
            to++;
        end
        chk("rr_first_hs", 64'(to < 50), 64'd1);
        chk("rr_loser_valid", 64'(g_dut[0].in1_if.wHdr_valid), 64'd1);
        chk("rr_loser_ready", 64'(g_dut[0].in1_if.wHdr_ready), 64'd0);
        wait_drain(0, "rr_drain");

        // Fixed priority: port 0 twice, then port 1, plus a single-beat port-1 frame
        push_frame(1, 0, mk(8'h20, 48'hFFFF_FFFF_FFFF, 16'h0806, 2, 16'h00FF), 2);
        push_frame(1, 0, mk(8'h22, 48'hFFFF_FFFF_FFFE, 16'h0806, 2, 16'h000F), 2);
        push_frame(1, 1, mk(8'h21, 48'h0012_3456_789A, 16'h0800, 2, 16'h3FFF), 2);
        wait_drain(1, "fp_drain");
        push_frame(1, 1, mk(8'h23, 48'h0012_3456_789B, 16'h0800, 1, 16'h0007), 1);
        wait_drain(1, "single_beat_drain");

        // Port 0 only, 3 beats, header one cycle after input handshake
        push_frame(0, 0, mk(8'h01, 48'hFFFF_FFFF_FFFF, 16'h0806, 3, 16'h003F), 3);
        @(negedge wClk);
        to = 0;
        while (!(g_dut[0].in0_if.wHdr_valid && g_dut[0].in0_if.wHdr_ready) && to < 50) begin
            @(negedge wClk);
            to++;
        end
        chk("p0_hs", 64'(to < 50), 64'd1);
        chk("p0_data_held_off", 64'(g_dut[0].in0_if.wData_ready), 64'd0);
        @(negedge wClk);
        chk("p0_hdr_valid_lat1", 64'(g_dut[0].out_if.wHdr_valid), 64'd1);
        chk("p0_hdr_dst",        64'(g_dut[0].out_if.bHdr_DstMacAddr), 64'hFFFF_FFFF_FFFF);
        chk("p0_hdr_type",       64'(g_dut[0].out_if.bHdr_FrameType), 64'h0806);
        chk("p0_grant",          64'(g_dut[0].grant_s), 64'd0);
        wait_drain(0, "p0_drain");

        // Backpressure: header held 5 cycles, then payload ready toggling
        hdr_rdy_v[0] = 1'b0;
        push_frame(0, 1, mk(8'h05, 48'h0055_6677_8899, 16'h0800, 4, 16'h1FFF), 4);
        @(negedge wClk);
        to = 0;
        while (!(g_dut[0].in1_if.wHdr_valid && g_dut[0].in1_if.wHdr_ready) && to < 50) begin
            @(negedge wClk);
            to++;
        end
        chk("bp_hs", 64'(to < 50), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge wClk);
            chk("bp_hdr_held",   64'(g_dut[0].out_if.wHdr_valid), 64'd1);
            chk("bp_hdr_stable", 64'(g_dut[0].out_if.bHdr_DstMacAddr), 64'h0055_6677_8899);
            chk("bp_no_dready",  64'(g_dut[0].in1_if.wData_ready), 64'd0);
        end
        @(posedge wClk);
        #1;
        hdr_rdy_v[0] = 1'b1;
        dat_rdy_v[0] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge wClk);
            #1;
            dat_rdy_v[0] = ~dat_rdy_v[0];
        end
        dat_rdy_v[0] = 1'b1;
        wait_drain(0, "bp_drain");

`ifdef MAC_TX_ARB_STATS_EN
        chk("stat_frames0_d0",  64'(g_dut[0].frames0_s), 64'd3);
        chk("stat_frames1_d0",  64'(g_dut[0].frames1_s), 64'd4);
        chk("stat_confl_d0_ge2", 64'(g_dut[0].conflicts_s >= 16'd2), 64'd1);
        chk("stat_frames0_d1",  64'(g_dut[1].frames0_s), 64'd2);
        chk("stat_frames1_d1",  64'(g_dut[1].frames1_s), 64'd2);
        chk("stat_confl_d1_ge2", 64'(g_dut[1].conflicts_s >= 16'd2), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
